// File: rtl/systolic3x3_top.sv
// systolic3x3_top: single-shot 3x3 output-stationary systolic multiplier with serial row-major readout
module systolic3x3_top #(
  parameter int data_size = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [data_size-1:0]   a1,
  input  logic [data_size-1:0]   a2,
  input  logic [data_size-1:0]   a3,
  input  logic [data_size-1:0]   b1,
  input  logic [data_size-1:0]   b2,
  input  logic [data_size-1:0]   b3,
  output logic [2*data_size:0]   out_data
);
  localparam int W  = data_size;
  localparam int PW = 2 * W;
  localparam int AW = 2 * W + 1;
  logic [4:0]    cnt_q, cnt_d;
  logic          win;
  logic [3:0]    idx;
  logic [W-1:0]  ag_d [3];
  logic [W-1:0]  bg_d [3];
  logic [W-1:0]  sa_q [3];
  logic [W-1:0]  sb_q [3];
  logic [W-1:0]  pa_q [3][3];
  logic [W-1:0]  pb_q [3][3];
  logic [AW-1:0] acc_q [9];
  logic [AW-1:0] acc_d [9];
  logic [AW-1:0] out_q, out_d;
  assign out_data = out_q;
  // Input gating to the 5-edge window, edge counter, MAC sums and readout select.
  always_comb begin
    win     = cnt_q <= 5'd4;
    ag_d[0] = win ? a1 : '0;
    ag_d[1] = win ? a2 : '0;
    ag_d[2] = win ? a3 : '0;
    bg_d[0] = win ? b1 : '0;
    bg_d[1] = win ? b2 : '0;
    bg_d[2] = win ? b3 : '0;
    cnt_d   = (cnt_q == 5'd19) ? cnt_q : cnt_q + 5'd1;
    idx     = 4'(cnt_q - 5'd10);
    out_d   = (cnt_q >= 5'd10 && cnt_q <= 5'd18) ? acc_q[idx] : '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        acc_d[3*r+c] = acc_q[3*r+c] + AW'(PW'(pa_q[r][c]) * PW'(pb_q[r][c]));
  end
  // State: the first PE column/row registers double as the port samplers; sa/sb add the skew.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      out_q <= '0;
      for (int i = 0; i < 3; i++) begin
        sa_q[i] <= '0;
        sb_q[i] <= '0;
        for (int j = 0; j < 3; j++) begin
          pa_q[i][j] <= '0;
          pb_q[i][j] <= '0;
        end
      end
      for (int i = 0; i < 9; i++) acc_q[i] <= '0;
    end else begin
      cnt_q      <= cnt_d;
      out_q      <= out_d;
      pa_q[0][0] <= ag_d[0];
      sa_q[0]    <= ag_d[1];
      pa_q[1][0] <= sa_q[0];
      sa_q[1]    <= ag_d[2];
      sa_q[2]    <= sa_q[1];
      pa_q[2][0] <= sa_q[2];
      pb_q[0][0] <= bg_d[0];
      sb_q[0]    <= bg_d[1];
      pb_q[0][1] <= sb_q[0];
      sb_q[1]    <= bg_d[2];
      sb_q[2]    <= sb_q[1];
      pb_q[0][2] <= sb_q[2];
      for (int i = 0; i < 3; i++)
        for (int j = 1; j < 3; j++) begin
          pa_q[i][j] <= pa_q[i][j-1];
          pb_q[j][i] <= pb_q[j-1][i];
        end
      for (int i = 0; i < 9; i++) acc_q[i] <= acc_d[i];
    end
  end
endmodule

// File: tb/tb_systolic3x3_top.sv
// tb_systolic3x3_top: directed and random frames checked against a matrix-product reference
module tb_systolic3x3_top;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] a1, a2, a3, b1, b2, b3;
  logic [4:0] out_data;
  int         n_pass = 0;
  int         n_tot  = 0;
  int         n_fail = 0;
  logic [1:0] sa [6][5];
  int         tab [9];
  bit         use_tab;
  bit         noise;

  systolic3x3_top #(.data_size(2)) dut (
    .clk(clk), .reset(reset),
    .a1(a1), .a2(a2), .a3(a3), .b1(b1), .b2(b2), .b3(b3),
    .out_data(out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] ref_c(input int n);
    int s = 0;
    for (int k = 0; k < 5; k++) s += int'(sa[n/3][k]) * int'(sa[3 + n%3][k]);
    return 5'(s % 32);
  endfunction

  function automatic logic [4:0] expect_at(input int e);
    if (e < 10 || e > 18) return 5'd0;
    return use_tab ? 5'(tab[e-10]) : ref_c(e - 10);
  endfunction

  task automatic clr();
    for (int p = 0; p < 6; p++) for (int k = 0; k < 5; k++) sa[p][k] = 2'd0;
    use_tab = 1'b0;
    noise   = 1'b0;
  endtask

  task automatic set_edge(input int k, input logic [1:0] x0, x1, x2, x3, x4, x5);
    sa[0][k] = x0; sa[1][k] = x1; sa[2][k] = x2;
    sa[3][k] = x3; sa[4][k] = x4; sa[5][k] = x5;
  endtask

  task automatic drive(input int e);
    if (e < 5) {a1, a2, a3, b1, b2, b3} = {sa[0][e], sa[1][e], sa[2][e], sa[3][e], sa[4][e], sa[5][e]};
    else if (noise) {a1, a2, a3, b1, b2, b3} = 12'($urandom);
    else {a1, a2, a3, b1, b2, b3} = '0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b0;
    {a1, a2, a3, b1, b2, b3} = 12'($urandom);
    repeat (2) @(posedge clk);
    #1 chk({tag, "_rst"}, out_data, 5'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run(input string tag, input int abort_at);
    for (int e = 0; e < 22; e++) begin
      drive(e);
      @(posedge clk);
      #1 chk($sformatf("%s_e%0d", tag, e), out_data, expect_at(e));
      if (e == abort_at) begin
        reset = 1'b0;
        #1 chk({tag, "_async_rst"}, out_data, 5'd0);
        return;
      end
    end
  endtask

  task automatic load_ref();
    clr();
    set_edge(1, 1, 2, 1, 1, 2, 3);
    set_edge(2, 3, 1, 2, 2, 1, 1);
    set_edge(3, 2, 2, 3, 3, 2, 3);
    use_tab = 1'b1;
    tab = '{13, 9, 12, 10, 9, 13, 14, 10, 14};
  endtask

  initial begin
    {a1, a2, a3, b1, b2, b3} = '0;
    load_ref();
    do_reset("ref");
    run("ref", -1);

    clr();
    set_edge(0, 1, 0, 0, 1, 2, 3);
    set_edge(1, 0, 1, 0, 2, 3, 1);
    set_edge(2, 0, 0, 1, 3, 1, 2);
    use_tab = 1'b1;
    tab = '{1, 2, 3, 2, 3, 1, 3, 1, 2};
    do_reset("ident");
    run("ident", -1);

    clr();
    for (int k = 0; k < 3; k++) set_edge(k, 3, 3, 3, 3, 3, 3);
    use_tab = 1'b1;
    tab = '{27, 27, 27, 27, 27, 27, 27, 27, 27};
    do_reset("max");
    run("max", -1);

    clr();
    for (int k = 0; k < 5; k++) set_edge(k, 3, 3, 3, 3, 3, 3);
    use_tab = 1'b1;
    tab = '{13, 13, 13, 13, 13, 13, 13, 13, 13};
    do_reset("wrap");
    run("wrap", -1);

    clr();
    do_reset("zero");
    run("zero", -1);

    load_ref();
    do_reset("abort");
    run("abort", 12);
    do_reset("rerun");
    run("rerun", -1);

    for (int t = 0; t < 4; t++) begin
      clr();
      noise = 1'b1;
      for (int p = 0; p < 6; p++) for (int k = 0; k < 5; k++) sa[p][k] = 2'($urandom);
      do_reset($sformatf("rnd%0d", t));
      run($sformatf("rnd%0d", t), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/systolic3x3_top.md
# systolic3x3_top

Top-level 3x3 output-stationary systolic matrix multiplier. It accepts one column of A and one row of B per clock on six 2-bit operand ports and accumulates C = A x B in a 3x3 grid of multiply-accumulate processing elements (PEs). After a fixed compute window it streams the nine 5-bit results out serially, row-major, on one port. It is a self-timed single-shot engine, restarted only by reset.

## Interface
- `data_size`, default 2: operand width in bits.
- `clk`, input, 1: sole clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset. `reset`=0 immediately clears all state.
- `a1`, `a2`, `a3`, input, `data_size` each: unsigned A operands. `a_i` carries A[i][k] in input cycle k.
- `b1`, `b2`, `b3`, input, `data_size` each: unsigned B operands. `b_j` carries B[k][j] in input cycle k.
- `out_data`, output, 2*`data_size`+1 (5): registered serial result stream.

## Operation
- **Edge numbering:** edge 0 is the first rising `clk` after `reset` goes high. A saturating cycle counter (0..19) tracks edges.
- **Input window:** edges 0..4, five samples.
  - All six ports are registered on every edge in the window.
  - Values sampled outside the window are ignored (treated as zero).
  - Zero samples inside the window contribute nothing to the result.
- **Skew:**
  - Row i A data passes through i-1 extra delay registers before PE(i,1).
  - Column j B data passes through j-1 extra delay registers before PE(1,j).
- **PE(i,j):**
  - Registers its a-input and forwards it to PE(i,j+1).
  - Registers its b-input and forwards it to PE(i+1,j).
  - On each edge computes acc <= acc + a_reg*b_reg.
- **Widths:**
  - Product is 2*`data_size` bits, unsigned.
  - Accumulator is 2*`data_size`+1 bits and wraps modulo 32.
- **Readout:** on edge 10+n (n=0..8), `out_data` <= C[n/3+1][n%3+1], giving the order C11, C12, C13, C21, …, C33.
  - On all other edges `out_data` <= 0.
  - After edge 19 the block idles with `out_data`=0 until the next reset.

## Timing
- **Reset (asynchronous, active-low):** `out_data`=0, all accumulators, skew/pipeline registers and the counter = 0.
- **Reset mid-operation:** aborts the frame. After release, edge 0 restarts the window and prior partial sums are lost.
- **Latency:** an operand sampled at edge c is accumulated in PE(i,j) at edge c+(i-1)+(j-1)+1.
  - The last sample (edge 4) reaches PE(3,3) at edge 9, so all sums are final before readout begins at edge 10.
- **Output validity:** C11 is valid from edge 10 to edge 11; C33 from edge 18 to edge 19.
- No handshake and no valid strobe. Position in the stream is defined purely by edge count from reset release.

## Test plan
- **Reference multiply:**
  - Edge 0: all zero.
  - Edges 1..3: (a1,a2,a3,b1,b2,b3) = (1,2,1,1,2,3), (3,1,2,2,1,1), (2,2,3,3,2,3).
  - Then zero.
  - → `out_data` after edges 10..18 = 13, 9, 12, 10, 9, 13, 14, 10, 14; 0 afterwards.
- **Identity:** A = I over edges 0..2 (cycle k: a_{k+1}=1), B rows = 1,2,3 / 2,3,1 / 3,1,2 → stream 1,2,3,2,3,1,3,1,2.
- **Max without overflow:** all ports = 3 on edges 0..2, zero on edges 3..4 → nine outputs of 27.
- **Wrap:** all ports = 3 on edges 0..4 → 45 mod 32 = 13 on all nine outputs.
- **Reset:**
  - Assert `reset`=0 during readout (e.g. after edge 12) → `out_data` becomes 0 immediately.
  - Release and rerun the reference multiply → identical stream, timed from the new edge 0.
- **All-zero inputs:** → `out_data` = 0 on every cycle.
